compress_stream_ctrl: RTL
=========================

// Module: compress_stream_ctrl
// PURPOSE
//  Ingress sequencer for the 8-lane compress datapath (5-stage, global-enable pipeline).
//  - Accepts AXI-stream beats, classifies each beat and builds the 36-bit flags word:
//    {valid, tkeep[31:0], tlast, flag_compression, is_header}.
//  - Drives the datapath's global enable. Inserts a flush beat after each compressed packet.
//  - Tracks in-flight beats and exposes per-packet statistics.
// PARAMETERS
//  DATA_WIDTH   32   lane width in bits; stream width = 8*DATA_WIDTH
//  TKEEP_WIDTH  32   stream byte-enable width
//  HDR_W        4    width of cfg_hdr_beats
//  PIPE_DEPTH   5    datapath latency in enabled cycles
//  CNT_W        16   width of statistics counters
// PORTS
//  clk            in   1                  clock, rising edge
//  reset          in   1                  synchronous, active-high
//  s_tdata        in   8*DATA_WIDTH       ingress data
//  s_tkeep        in   TKEEP_WIDTH        ingress byte enables
//  s_tlast        in   1                  ingress end of packet
//  s_tvalid       in   1                  ingress valid
//  s_tready       out  1                  ingress ready
//  cfg_compress   in   1                  compress enable; sampled at the first beat of each packet
//  cfg_hdr_beats  in   HDR_W              header beats per packet, 0..15; sampled at the first beat
//  cu_wrtEn       out  1                  datapath global enable
//  cu_dataIn      out  8*DATA_WIDTH       datapath data
//  cu_flags_in    out  TKEEP_WIDTH+4      datapath flags
//  cu_out_valid   in   1                  datapath flags_out[TKEEP_WIDTH+3]
//  m_tready       in   1                  egress ready
//  busy           out  1                  beats in flight or a packet is open
//  pkt_count      out  CNT_W              completed packets (egress tlast handshakes)
//  beat_count     out  CNT_W              accepted ingress beats
// BEHAVIOUR
//  - Enable rule: cu_wrtEn = ~(cu_out_valid & ~m_tready). This is combinational. The pipeline freezes only while its output is stalled.
//  - Ingress handshake: s_tready = cu_wrtEn & (state != FLUSH).
//    A beat is accepted when s_tvalid & s_tready.
//  - Drive: cu_dataIn and cu_flags_in are combinational from the current beat and state.
//    No beat is presented in a cycle -> valid bit = 0 and data = 0. That cycle is a bubble.
//  - FSM states: IDLE, HDR, BODY, FLUSH.
//    IDLE : first accepted beat latches cfg_compress -> cmp_r and cfg_hdr_beats -> hdr_left.
//           hdr_left != 0 -> HDR, and this beat is a header beat. hdr_left == 0 -> BODY, and this beat is a body beat.
//    HDR  : is_header = 1 on each accepted beat; hdr_left decrements.
//           Leaves HDR for BODY when hdr_left reaches 0.
//    BODY : is_header = 0; flag_compression = cmp_r.
//    tlast accepted in HDR or BODY:
//      cmp_r = 1 and beat is a body beat -> FLUSH, with tlast withheld on this beat.
//      otherwise -> IDLE, with tlast passed through.
//    FLUSH: presents one synthetic beat when cu_wrtEn = 1:
//           data 0, tkeep 32'h0000_0003 (carried half-lane), tlast 1, flag_compression 1, is_header 0.
//           Then -> IDLE. No ingress is accepted in FLUSH.
//    Single-beat packet that is a header (first beat with tlast, hdr_left != 0) -> straight to IDLE, no flush.
//  - Occupancy: inflight counter, 0..PIPE_DEPTH.
//    Increment when a valid beat enters (accepted beat or flush beat, with cu_wrtEn = 1).
//    Decrement when cu_out_valid & m_tready.
//    Simultaneous increment and decrement -> unchanged.
//    Overflow is impossible; assertion: inflight <= PIPE_DEPTH.
//  - busy = (inflight != 0) | (state != IDLE).
//  - Counters:
//    beat_count increments on each ingress handshake.
//    pkt_count increments on each egress beat with tlast (the bench supplies tlast from the flags_out tap).
//    Both wrap modulo 2^CNT_W.
//  - Reset: state IDLE, cmp_r 0, hdr_left 0, inflight 0, counters 0.
//    cu_flags_in valid bit = 0 and cu_dataIn = 0 while reset is asserted. The datapath clears alongside.
//    Reset mid-packet discards the partial packet; no flush beat is issued.
//  - Config changes mid-packet have no effect until the next first beat.
// STRUCTURE
//  - Shared package compress_pkg:
//    flag bit indices (VALID_B, TKEEP_LSB, TLAST_B, CMP_B, HDR_B), the state enum, PIPE_DEPTH.
//  - One natural sub-module: occupancy_counter (up/down, saturation assert).
//  - Everything else is inline FSM and muxes.
// TESTING
//  - cfg_compress=0, hdr=1, 3-beat packet, m_tready=1 -> flags is_header 1,0,0; cmp 0; tlast on beat 3; no flush; s_tready held 1.
//  - cfg_compress=1, hdr=1, 4-beat packet -> beats 2-4 have cmp=1; beat 4 has tlast=0; 5th beat is the flush (tkeep 0x3, tlast=1); busy drops 5 cycles after the flush.
//  - Hold m_tready=0 while cu_out_valid=1 -> cu_wrtEn=0 and s_tready=0; cu_flags_in stable; inflight unchanged. Release -> resumes without loss.
//  - cfg_hdr_beats=0, compress on, 1-beat packet with tlast -> body beat, then flush; pkt_count +1 after egress.
//  - Reset asserted in BODY of a compressed packet -> next cycle state IDLE, inflight 0, counters 0; no flush beat seen.
//  - Toggle cfg_compress mid-packet -> flag_compression constant for the packet; the new value applies to the next packet.

Source files
------------

// File: rtl/compress_stream_ctrl_pkg.sv
// Shared types and constants for the compress ingress sequencer.
// Flag word layout: {valid, tkeep, tlast, flag_compression, is_header}.
package compress_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int TKEEP_WIDTH = 32;
  localparam int HDR_W       = 4;
  localparam int PIPE_DEPTH  = 5;
  localparam int CNT_W       = 16;

  localparam int STREAM_W = 8 * DATA_WIDTH;
  localparam int FLAG_W   = TKEEP_WIDTH + 4;
  localparam int OCC_W    = $clog2(PIPE_DEPTH + 1);

  localparam int VALID_B   = TKEEP_WIDTH + 3;
  localparam int TKEEP_LSB = 3;
  localparam int TLAST_B   = 2;
  localparam int CMP_B     = 1;
  localparam int HDR_B     = 0;

  // The flush beat carries the leftover half-lane.
  localparam logic [TKEEP_WIDTH-1:0] FLUSH_KEEP =
    TKEEP_WIDTH'(3);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    FLUSH
  } state_e;

endpackage

// File: rtl/compress_stream_ctrl_if.sv
// Ingress AXI-stream bundle for compress_stream_ctrl.
// master drives tdata/tkeep/tlast/tvalid; slave drives tready.
interface compress_stream_ctrl_if;
  import compress_pkg::*;

  logic [STREAM_W-1:0]    s_tdata;
  logic [TKEEP_WIDTH-1:0] s_tkeep;
  logic                   s_tlast;
  logic                   s_tvalid;
  logic                   s_tready;

  modport master (
    output s_tdata,
    output s_tkeep,
    output s_tlast,
    output s_tvalid,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tkeep,
    input  s_tlast,
    input  s_tvalid,
    output s_tready
  );

endinterface

// File: rtl/compress_stream_ctrl_occupancy_counter.sv
// Up/down count of valid beats held inside the datapath.
// Ports: clk, reset, inc (beat enters), dec (beat leaves), count.
module occupancy_counter
  import compress_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc & ~dec) begin
      count <= count + OCC_W'(1);
    end else if (dec & ~inc) begin
      count <= count - OCC_W'(1);
    end
  end

  // The datapath cannot hold more beats than it has stages.
  occNoOverflow: assert property (
    @(posedge clk) disable iff (reset)
    count <= OCC_W'(PIPE_DEPTH)
  );

endmodule

// File: rtl/compress_stream_ctrl.sv
// Ingress sequencer: classifies beats, builds datapath flags,
// drives global enable, inserts a flush after compressed packets.
// Ports: clk/reset, sIf (ingress stream), cfg_*, cu_* datapath
// side, m_tready, busy, pkt_count, beat_count.
// cu_out_last is the datapath flags_out tlast tap.
module compress_stream_ctrl
  import compress_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  compress_stream_ctrl_if.slave  sIf,
  input  logic                   cfg_compress,
  input  logic [HDR_W-1:0]       cfg_hdr_beats,
  output logic                   cu_wrtEn,
  output logic [STREAM_W-1:0]    cu_dataIn,
  output logic [FLAG_W-1:0]      cu_flags_in,
  input  logic                   cu_out_valid,
  input  logic                   cu_out_last,
  input  logic                   m_tready,
  output logic                   busy,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       beat_count
);

  state_e           stateQ;
  state_e           stateD;
  logic             cmpR;
  logic             cmpD;
  logic [HDR_W-1:0] hdrLeft;
  logic [HDR_W-1:0] hdrD;

  logic             accept;
  logic             flushGo;
  logic             egress;
  logic             firstBeat;
  logic             curCmp;
  logic [HDR_W-1:0] hdrCnt;
  logic             isHdr;
  logic             needFlush;
  logic [OCC_W-1:0] inflight;

  assign cu_wrtEn = ~(cu_out_valid & ~m_tready);

  assign sIf.s_tready =
    cu_wrtEn & (stateQ != FLUSH) & ~reset;

  assign accept  = sIf.s_tvalid & sIf.s_tready;
  assign flushGo = cu_wrtEn & (stateQ == FLUSH) & ~reset;
  assign egress  = cu_out_valid & m_tready;

  // In IDLE the beat uses live config; later beats use the
  // values latched at the first beat. hdrLeft is 0 in BODY.
  assign firstBeat = stateQ == IDLE;
  assign curCmp    = firstBeat ? cfg_compress : cmpR;
  assign hdrCnt    = firstBeat ? cfg_hdr_beats : hdrLeft;
  assign isHdr     = hdrCnt != '0;
  assign needFlush = curCmp & ~isHdr & sIf.s_tlast;

  always_comb begin
    stateD      = stateQ;
    cmpD        = cmpR;
    hdrD        = hdrLeft;
    cu_dataIn   = '0;
    cu_flags_in = '0;
    unique case (1'b1)
      flushGo: begin
        stateD = IDLE;
        cu_flags_in[VALID_B] = 1'b1;
        cu_flags_in[TKEEP_LSB +: TKEEP_WIDTH] = FLUSH_KEEP;
        cu_flags_in[TLAST_B] = 1'b1;
        cu_flags_in[CMP_B]   = 1'b1;
      end
      accept: begin
        cmpD      = curCmp;
        hdrD      = isHdr ? hdrCnt - HDR_W'(1) : '0;
        cu_dataIn = sIf.s_tdata;
        cu_flags_in[VALID_B] = 1'b1;
        cu_flags_in[TKEEP_LSB +: TKEEP_WIDTH] = sIf.s_tkeep;
        // tlast moves onto the flush beat when one follows.
        cu_flags_in[TLAST_B] = sIf.s_tlast & ~needFlush;
        cu_flags_in[CMP_B]   = curCmp & ~isHdr;
        cu_flags_in[HDR_B]   = isHdr;
        if (needFlush) begin
          stateD = FLUSH;
          hdrD   = '0;
        end else if (sIf.s_tlast) begin
          stateD = IDLE;
          hdrD   = '0;
        end else if (hdrD != '0) begin
          stateD = HDR;
        end else begin
          stateD = BODY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= IDLE;
      cmpR       <= 1'b0;
      hdrLeft    <= '0;
      pkt_count  <= '0;
      beat_count <= '0;
    end else begin
      stateQ  <= stateD;
      cmpR    <= cmpD;
      hdrLeft <= hdrD;
      if (accept) begin
        beat_count <= beat_count + CNT_W'(1);
      end
      if (egress & cu_out_last) begin
        pkt_count <= pkt_count + CNT_W'(1);
      end
    end
  end

  occupancy_counter uOcc (
    .clk   (clk),
    .reset (reset),
    .inc   (cu_flags_in[VALID_B]),
    .dec   (egress),
    .count (inflight)
  );

  assign busy = (inflight != '0) | (stateQ != IDLE);

endmodule
